// File: rtl/latency_stats.sv
// Two-stage latency statistics collector: last/min/max/sum/count/EMA plus
// limit-violation and reject bookkeeping, one sample per cycle.
module latency_stats #(
  parameter int SUM_W     = 48,
  parameter int CNT_W     = 32,
  parameter int EMA_SHIFT = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_sample_valid,
  input  logic [31:0]      i_sample,
  input  logic [31:0]      i_limit,
  output logic             o_update,
  output logic             o_stats_valid,
  output logic [31:0]      o_last_latency,
  output logic [31:0]      o_min_latency,
  output logic [31:0]      o_max_latency,
  output logic [31:0]      o_avg_latency,
  output logic [SUM_W-1:0] o_sum_latency,
  output logic [CNT_W-1:0] o_sample_count,
  output logic [15:0]      o_reject_count,
  output logic             o_violation,
  output logic [CNT_W-1:0] o_violation_count
);

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Stage 1 registers
  logic        r_s1_valid;
  logic [31:0] r_s1_sample;
  logic        r_s1_accept;
  logic        r_s1_viol;

  // Stage 2 registers
  state_t           r_state;
  state_t           w_state_next;
  logic             r_update;
  logic [31:0]      r_last;
  logic [31:0]      r_min;
  logic [31:0]      r_max;
  logic [31:0]      r_avg;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_rej;
  logic             r_viol;
  logic [CNT_W-1:0] r_viol_cnt;

  logic w_accept;
  logic w_viol;
  logic w_acc;
  logic w_rej;
  logic w_first;

  logic signed [32:0] w_diff;
  logic signed [32:0] w_step;
  logic signed [32:0] w_avg_sum;
  logic [31:0]        w_avg_next;

  logic [SUM_W:0]   w_sum_ext;
  logic [SUM_W-1:0] w_sum_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_viol_cnt_next;
  logic [15:0]      w_rej_next;
  logic [31:0]      w_min_next;
  logic [31:0]      w_max_next;

  // Sample is a signed int; the limit check reuses its raw bits as unsigned.
  assign w_accept = ($signed(i_sample) > 32'sd0);
  assign w_viol   = w_accept && (i_limit != 32'd0) && (i_sample > i_limit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sample <= 32'd0;
      r_s1_accept <= 1'b0;
      r_s1_viol   <= 1'b0;
    end else if (i_clear) begin
      r_s1_valid  <= 1'b0;
      r_s1_sample <= 32'd0;
      r_s1_accept <= 1'b0;
      r_s1_viol   <= 1'b0;
    end else begin
      r_s1_valid  <= i_sample_valid;
      r_s1_sample <= i_sample;
      r_s1_accept <= w_accept;
      r_s1_viol   <= w_viol;
    end
  end

  assign w_acc   = r_s1_valid && r_s1_accept;
  assign w_rej   = r_s1_valid && !r_s1_accept;
  assign w_first = w_acc && (r_state == ST_EMPTY);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_clear) begin
      w_state_next = ST_EMPTY;
    end else if (w_acc) begin
      w_state_next = ST_ACTIVE;
    end
  end

  // EMA step in 33 bits; the arithmetic shift floors toward -inf, which keeps
  // the average inside [min, max] for both rising and falling inputs.
  always_comb begin
    w_diff     = $signed({r_s1_sample[31], r_s1_sample}) - $signed({r_avg[31], r_avg});
    w_step     = w_diff >>> EMA_SHIFT;
    w_avg_sum  = $signed({r_avg[31], r_avg}) + w_step;
    w_avg_next = w_avg_sum[31:0];
  end

  always_comb begin
    w_sum_ext       = {1'b0, r_sum} + {{(SUM_W + 1 - 32){1'b0}}, r_s1_sample};
    w_sum_next      = w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
    w_cnt_next      = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    w_viol_cnt_next = (r_viol_cnt == {CNT_W{1'b1}}) ? r_viol_cnt : r_viol_cnt + CNT_W'(1);
    w_rej_next      = (r_rej == 16'hFFFF) ? r_rej : r_rej + 16'd1;
    w_min_next      = (r_s1_sample < r_min) ? r_s1_sample : r_min;
    w_max_next      = (r_s1_sample > r_max) ? r_s1_sample : r_max;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_update   <= 1'b0;
      r_last     <= 32'd0;
      r_min      <= 32'hFFFF_FFFF;
      r_max      <= 32'd0;
      r_avg      <= 32'd0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_rej      <= 16'd0;
      r_viol     <= 1'b0;
      r_viol_cnt <= '0;
    end else if (i_clear) begin
      r_update   <= 1'b0;
      r_last     <= 32'd0;
      r_min      <= 32'hFFFF_FFFF;
      r_max      <= 32'd0;
      r_avg      <= 32'd0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_rej      <= 16'd0;
      r_viol     <= 1'b0;
      r_viol_cnt <= '0;
    end else begin
      r_update <= w_acc;
      if (w_rej) begin
        r_rej <= w_rej_next;
      end
      if (w_first) begin
        r_last <= r_s1_sample;
        r_min  <= r_s1_sample;
        r_max  <= r_s1_sample;
        r_avg  <= r_s1_sample;
        r_sum  <= {{(SUM_W - 32){1'b0}}, r_s1_sample};
        r_cnt  <= CNT_W'(1);
      end else if (w_acc) begin
        r_last <= r_s1_sample;
        r_min  <= w_min_next;
        r_max  <= w_max_next;
        r_avg  <= w_avg_next;
        r_sum  <= w_sum_next;
        r_cnt  <= w_cnt_next;
      end
      if (w_acc && r_s1_viol) begin
        r_viol     <= 1'b1;
        r_viol_cnt <= w_viol_cnt_next;
      end
    end
  end

  assign o_update          = r_update;
  assign o_stats_valid     = (r_state == ST_ACTIVE);
  assign o_last_latency    = r_last;
  assign o_min_latency     = r_min;
  assign o_max_latency     = r_max;
  assign o_avg_latency     = r_avg;
  assign o_sum_latency     = r_sum;
  assign o_sample_count    = r_cnt;
  assign o_reject_count    = r_rej;
  assign o_violation       = r_viol;
  assign o_violation_count = r_viol_cnt;

endmodule

// File: tb/tb_latency_stats.sv
// Directed bench for latency_stats: default instance plus a narrow-counter
// instance for saturation.
module tb_latency_stats;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        sv = 1'b0;
  logic [31:0] smp = 32'd0;
  logic [31:0] lim = 32'd0;

  logic        upd, stv, viol;
  logic [31:0] last_l, min_l, max_l, avg_l;
  logic [47:0] sum_l;
  logic [31:0] cnt, vcnt;
  logic [15:0] rej;

  logic        b_sv = 1'b0;
  logic [31:0] b_smp = 32'd0;
  logic        b_upd, b_stv, b_viol;
  logic [31:0] b_last, b_min, b_max, b_avg;
  logic [32:0] b_sum;
  logic [1:0]  b_cnt, b_vcnt;
  logic [15:0] b_rej;

  int vectors = 0;
  int miscompares = 0;
  int upd_seen;

  always #5 clk = ~clk;

  latency_stats dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_sample_valid(sv),
    .i_sample(smp), .i_limit(lim), .o_update(upd), .o_stats_valid(stv),
    .o_last_latency(last_l), .o_min_latency(min_l), .o_max_latency(max_l),
    .o_avg_latency(avg_l), .o_sum_latency(sum_l), .o_sample_count(cnt),
    .o_reject_count(rej), .o_violation(viol), .o_violation_count(vcnt)
  );

  latency_stats #(.SUM_W(33), .CNT_W(2), .EMA_SHIFT(3)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_sample_valid(b_sv),
    .i_sample(b_smp), .i_limit(32'd0), .o_update(b_upd), .o_stats_valid(b_stv),
    .o_last_latency(b_last), .o_min_latency(b_min), .o_max_latency(b_max),
    .o_avg_latency(b_avg), .o_sum_latency(b_sum), .o_sample_count(b_cnt),
    .o_reject_count(b_rej), .o_violation(b_viol), .o_violation_count(b_vcnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] s, input logic [31:0] l, input logic c);
    sv    = v;
    smp   = s;
    lim   = l;
    clear = c;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".update"}, 64'(upd), 64'd0);
    check({tag, ".stats_valid"}, 64'(stv), 64'd0);
    check({tag, ".last"}, 64'(last_l), 64'd0);
    check({tag, ".min"}, 64'(min_l), 64'hFFFF_FFFF);
    check({tag, ".max"}, 64'(max_l), 64'd0);
    check({tag, ".avg"}, 64'(avg_l), 64'd0);
    check({tag, ".sum"}, 64'(sum_l), 64'd0);
    check({tag, ".count"}, 64'(cnt), 64'd0);
    check({tag, ".reject"}, 64'(rej), 64'd0);
    check({tag, ".violation"}, 64'(viol), 64'd0);
    check({tag, ".vcount"}, 64'(vcnt), 64'd0);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    check_reset_state("rst");
    check("rst.sat_sum", 64'(b_sum), 64'd0);
    rst_n = 1'b1;

    // Samples 10, 4, 25 back-to-back, limit disabled
    drive(1, 32'd10, 32'd0, 0); tick();
    check("t1.upd_lat0", 64'(upd), 64'd0);
    drive(1, 32'd4, 32'd0, 0); tick();
    check("t1.upd_a", 64'(upd), 64'd1);
    check("t1.last_a", 64'(last_l), 64'd10);
    check("t1.avg_a", 64'(avg_l), 64'd10);
    check("t1.stv_a", 64'(stv), 64'd1);
    drive(1, 32'd25, 32'd0, 0); tick();
    check("t1.upd_b", 64'(upd), 64'd1);
    check("t1.min_b", 64'(min_l), 64'd4);
    check("t1.avg_b", 64'(avg_l), 64'd9);
    drive(0, 32'd0, 32'd0, 0); tick();
    check("t1.upd_c", 64'(upd), 64'd1);
    check("t1.last", 64'(last_l), 64'd25);
    check("t1.min", 64'(min_l), 64'd4);
    check("t1.max", 64'(max_l), 64'd25);
    check("t1.sum", 64'(sum_l), 64'd39);
    check("t1.count", 64'(cnt), 64'd3);
    check("t1.avg", 64'(avg_l), 64'd11);
    check("t1.violation", 64'(viol), 64'd0);
    tick();
    check("t1.upd_end", 64'(upd), 64'd0);

    // Rejected samples -1 and 0, then 7
    drive(0, 32'd0, 32'd0, 1); tick();
    check("t2.clr_count", 64'(cnt), 64'd0);
    upd_seen = 0;
    drive(1, 32'hFFFF_FFFF, 32'd0, 0); tick(); upd_seen += int'(upd);
    drive(1, 32'd0, 32'd0, 0); tick(); upd_seen += int'(upd);
    check("t2.reject_1", 64'(rej), 64'd1);
    drive(1, 32'd7, 32'd0, 0); tick(); upd_seen += int'(upd);
    drive(0, 32'd0, 32'd0, 0); tick(); upd_seen += int'(upd);
    check("t2.reject", 64'(rej), 64'd2);
    check("t2.count", 64'(cnt), 64'd1);
    check("t2.min", 64'(min_l), 64'd7);
    check("t2.max", 64'(max_l), 64'd7);
    check("t2.last", 64'(last_l), 64'd7);
    tick(); upd_seen += int'(upd);
    check("t2.updates", 64'(upd_seen), 64'd1);

    // EMA: 80 then 16 -> 72
    drive(0, 32'd0, 32'd0, 1); tick();
    drive(1, 32'd80, 32'd0, 0); tick();
    drive(1, 32'h10, 32'd0, 0); tick();
    check("t3.avg_first", 64'(avg_l), 64'd80);
    drive(0, 32'd0, 32'd0, 0); tick();
    check("t3.avg_second", 64'(avg_l), 64'd72);

    // Limit 20: 20 ok, 21 and 100 violate; limit captured with its sample
    drive(0, 32'd0, 32'd0, 1); tick();
    drive(1, 32'd20, 32'd20, 0); tick();
    drive(1, 32'd21, 32'd20, 0); tick();
    check("t4.viol_at20", 64'(viol), 64'd0);
    drive(1, 32'd100, 32'd20, 0); tick();
    check("t4.viol_at21", 64'(viol), 64'd1);
    check("t4.vcount_21", 64'(vcnt), 64'd1);
    drive(1, 32'd5, 32'd0, 0); tick();
    check("t4.vcount_100", 64'(vcnt), 64'd2);
    drive(1, 32'd5, 32'd20, 0); tick();
    drive(1, 32'd1000, 32'd0, 0); tick();
    drive(0, 32'd0, 32'd0, 0); tick();
    check("t4.viol_sticky", 64'(viol), 64'd1);
    check("t4.vcount", 64'(vcnt), 64'd2);
    check("t4.max", 64'(max_l), 64'd1000);

    // clear together with 50, while 30 sits in stage 1
    drive(1, 32'd30, 32'd0, 0); tick();
    drive(1, 32'd50, 32'd0, 1); tick();
    check_reset_state("t5");
    drive(1, 32'd9, 32'd0, 0); tick();
    check("t5.upd_none", 64'(upd), 64'd0);
    check("t5.count_none", 64'(cnt), 64'd0);
    drive(0, 32'd0, 32'd0, 0); tick();
    check("t5.min", 64'(min_l), 64'd9);
    check("t5.max", 64'(max_l), 64'd9);
    check("t5.count", 64'(cnt), 64'd1);
    check("t5.stv", 64'(stv), 64'd1);

    // Saturation on the narrow instance: five samples of 0x7FFF_FFFF
    b_sv = 1'b1; b_smp = 32'h7FFF_FFFF;
    repeat (5) tick();
    b_sv = 1'b0; b_smp = 32'd0;
    tick();
    check("t6.sum", 64'(b_sum), 64'h1_FFFF_FFFF);
    check("t6.count", 64'(b_cnt), 64'd3);
    check("t6.min", 64'(b_min), 64'h7FFF_FFFF);
    check("t6.max", 64'(b_max), 64'h7FFF_FFFF);
    check("t6.last", 64'(b_last), 64'h7FFF_FFFF);

    // Asynchronous reset takes effect without a clock edge
    rst_n = 1'b0;
    #1;
    check("t7.async_cnt", 64'(b_cnt), 64'd0);
    check("t7.async_min", 64'(min_l), 64'hFFFF_FFFF);
    check("t7.async_stv", 64'(stv), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
